// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared stall/flush encodings and FSM state codes, decoded by every pipeline register.
package pipe_stall_ctrl_pkg;

    localparam logic       RstEnable  = 1'b1;

    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_MEM  = 6'b011111;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_MC_WAIT = 1'b1
    } mc_state_e;

endpackage

// File: rtl/pipe_mc_timer.sv
// Multi-cycle countdown: clear beats load beats decrement; never decrements below zero.
module pipe_mc_timer
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign zero = (cnt_q == '0);

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline hazard controller: merges stall requests, times multi-cycle EX ops, issues exception flushes.
// Optional STALL_PERF_EN adds saturating stall-cycle and flush performance counters.
module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int CNT_W  = 6,
    parameter int PERF_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stallreq_id,
    input  logic              stallreq_ex,
    input  logic              stallreq_mem,
    input  logic              mc_start,
    input  logic [CNT_W-1:0]  mc_cycles,
    input  logic              mc_done,
    input  logic              excp_valid,
    input  logic [31:0]       excp_vector,
`ifdef STALL_PERF_EN
    output logic [PERF_W-1:0] perf_stall_cycles,
    output logic [PERF_W-1:0] perf_flush_cnt,
`endif
    output logic [5:0]        stall,
    output logic              flush,
    output logic [31:0]       new_pc,
    output logic              mc_busy,
    output logic              mc_ready
);

    mc_state_e        state_q, state_d;
    logic             tmr_clr, tmr_load, tmr_dec, tmr_zero;
    logic [CNT_W-1:0] tmr_cnt, tmr_load_val;
    logic             ex_hold;
    logic             in_rst;

    assign in_rst       = (rst == RstEnable);
    assign tmr_load_val = (mc_cycles == '0) ? '0 : mc_cycles - {{(CNT_W-1){1'b0}}, 1'b1};

    pipe_mc_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clr      (tmr_clr),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .dec      (tmr_dec),
        .cnt      (tmr_cnt),
        .zero     (tmr_zero)
    );

    always_ff @(posedge clk) begin
        if (in_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        tmr_clr  = 1'b0;
        tmr_load = 1'b0;
        tmr_dec  = 1'b0;
        ex_hold  = stallreq_ex;
        stall    = STALL_NONE;
        flush    = 1'b0;
        new_pc   = 32'h0;
        mc_ready = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (mc_start) begin
                    tmr_load = 1'b1;
                    state_d  = ST_MC_WAIT;
                    ex_hold  = 1'b1;
                end
            end
            ST_MC_WAIT: begin
                if (tmr_zero || mc_done) begin
                    // A MEM stall defers the ready pulse; park at zero until it clears.
                    if (stallreq_mem) begin
                        tmr_clr = 1'b1;
                    end else begin
                        mc_ready = 1'b1;
                        state_d  = ST_IDLE;
                    end
                end else begin
                    tmr_dec = 1'b1;
                    ex_hold = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (excp_valid) begin
            flush    = 1'b1;
            new_pc   = excp_vector;
            mc_ready = 1'b0;
            state_d  = ST_IDLE;
            tmr_clr  = 1'b1;
            tmr_load = 1'b0;
            tmr_dec  = 1'b0;
        end else if (stallreq_mem) begin
            stall = STALL_MEM;
        end else if (ex_hold) begin
            stall = STALL_EX;
        end else if (stallreq_id) begin
            stall = STALL_ID;
        end

        if (in_rst) begin
            stall    = STALL_NONE;
            flush    = 1'b0;
            new_pc   = 32'h0;
            mc_ready = 1'b0;
        end
    end

    assign mc_busy = !in_rst && (state_q == ST_MC_WAIT);

`ifdef STALL_PERF_EN
    logic [PERF_W-1:0] perf_stall_q, perf_stall_d;
    logic [PERF_W-1:0] perf_flush_q, perf_flush_d;

    always_comb begin
        perf_stall_d = perf_stall_q;
        perf_flush_d = perf_flush_q;
        if ((stall != STALL_NONE) && (perf_stall_q != '1)) begin
            perf_stall_d = perf_stall_q + {{(PERF_W-1){1'b0}}, 1'b1};
        end
        if (flush && (perf_flush_q != '1)) begin
            perf_flush_d = perf_flush_q + {{(PERF_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (in_rst) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_flush_q <= perf_flush_d;
        end
    end

    assign perf_stall_cycles = in_rst ? '0 : perf_stall_q;
    assign perf_flush_cnt    = in_rst ? '0 : perf_flush_q;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed-vector bench for pipe_stall_ctrl; inputs change 1ns after posedge, outputs sampled 2ns later.
module tb_pipe_stall_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallreq_id, stallreq_ex, stallreq_mem;
    logic        mc_start, mc_done, excp_valid;
    logic [5:0]  mc_cycles;
    logic [31:0] excp_vector;
    logic [5:0]  stall;
    logic        flush, mc_busy, mc_ready;
    logic [31:0] new_pc;
`ifdef STALL_PERF_EN
    logic [31:0] perf_stall_cycles, perf_flush_cnt;
`endif

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pipe_stall_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .stallreq_id  (stallreq_id),
        .stallreq_ex  (stallreq_ex),
        .stallreq_mem (stallreq_mem),
        .mc_start     (mc_start),
        .mc_cycles    (mc_cycles),
        .mc_done      (mc_done),
        .excp_valid   (excp_valid),
        .excp_vector  (excp_vector),
`ifdef STALL_PERF_EN
        .perf_stall_cycles (perf_stall_cycles),
        .perf_flush_cnt    (perf_flush_cnt),
`endif
        .stall        (stall),
        .flush        (flush),
        .new_pc       (new_pc),
        .mc_busy      (mc_busy),
        .mc_ready     (mc_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic nxt;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in;
        stallreq_id = 0; stallreq_ex = 0; stallreq_mem = 0;
        mc_start = 0; mc_done = 0; excp_valid = 0;
        mc_cycles = 0; excp_vector = 0;
    endtask

    task automatic chk_out(input string tag, input logic [5:0] e_stall, input logic e_flush,
                           input logic [31:0] e_pc, input logic e_busy, input logic e_ready);
        chk({tag, ".stall"}, {26'h0, stall}, {26'h0, e_stall});
        chk({tag, ".flush"}, {31'h0, flush}, {31'h0, e_flush});
        chk({tag, ".new_pc"}, new_pc, e_pc);
        chk({tag, ".busy"}, {31'h0, mc_busy}, {31'h0, e_busy});
        chk({tag, ".ready"}, {31'h0, mc_ready}, {31'h0, e_ready});
    endtask

    initial begin
        // Reset with every request asserted: all outputs must stay low.
        rst = 1; stallreq_id = 1; stallreq_ex = 1; stallreq_mem = 1;
        mc_start = 1; mc_cycles = 6'd5; mc_done = 1; excp_valid = 1; excp_vector = 32'hDEAD_BEEF;
        #2;
        chk_out("rst0", 6'b000000, 0, 32'h0, 0, 0);
        nxt; #2;
        chk_out("rst1", 6'b000000, 0, 32'h0, 0, 0);
        nxt;
        rst = 0; idle_in; stallreq_id = 1; #2;
        chk_out("id", 6'b000111, 0, 32'h0, 0, 0);

        nxt; stallreq_ex = 1; #2;
        chk("id_ex", {26'h0, stall}, 32'b001111);
        nxt; stallreq_mem = 1; #2;
        chk("id_ex_mem", {26'h0, stall}, 32'b011111);

        // N=4: stalls T..T+3, busy T+1..T+4, ready at T+4.
        nxt; idle_in; mc_start = 1; mc_cycles = 6'd4; #2;
        chk_out("mc4_t0", 6'b001111, 0, 32'h0, 0, 0);
        for (int k = 1; k <= 4; k++) begin
            nxt; mc_start = 0; #2;
            chk_out($sformatf("mc4_t%0d", k), (k < 4) ? 6'b001111 : 6'b000000, 0, 32'h0, 1, (k == 4));
        end
        nxt; #2;
        chk_out("mc4_t5", 6'b000000, 0, 32'h0, 0, 0);

        // N=32 cut short by mc_done at T+5.
        nxt; mc_start = 1; mc_cycles = 6'd32; #2;
        chk("mc32_t0.stall", {26'h0, stall}, 32'b001111);
        for (int k = 1; k <= 4; k++) begin
            nxt; mc_start = 0; #2;
            chk($sformatf("mc32_t%0d.stall", k), {26'h0, stall}, 32'b001111);
        end
        nxt; mc_done = 1; #2;
        chk_out("mc32_t5", 6'b000000, 0, 32'h0, 1, 1);
        nxt; mc_done = 0; #2;
        chk_out("mc32_t6", 6'b000000, 0, 32'h0, 0, 0);

        // N=0 behaves as N=1.
        nxt; mc_start = 1; mc_cycles = 6'd0; #2;
        chk_out("mc0_t0", 6'b001111, 0, 32'h0, 0, 0);
        nxt; mc_start = 0; #2;
        chk_out("mc0_t1", 6'b000000, 0, 32'h0, 1, 1);
        nxt; #2;
        chk("mc0_t2.busy", {31'h0, mc_busy}, 32'h0);

        // Exception aborts an op with cnt=10.
        nxt; mc_start = 1; mc_cycles = 6'd11; #2;
        chk("exc_t0.stall", {26'h0, stall}, 32'b001111);
        nxt; mc_start = 0; excp_valid = 1; excp_vector = 32'h0000_0180; #2;
        chk_out("exc_t1", 6'b000000, 1, 32'h0000_0180, 1, 0);
        nxt; excp_valid = 0; excp_vector = 32'h0000_0180; #2;
        chk_out("exc_t2", 6'b000000, 0, 32'h0, 0, 0);

        // MEM stall defers mc_ready while the countdown still runs.
        nxt; excp_vector = 0; mc_start = 1; mc_cycles = 6'd2; #2;
        chk("mem_t0.stall", {26'h0, stall}, 32'b001111);
        nxt; mc_start = 0; stallreq_mem = 1; #2;
        chk_out("mem_t1", 6'b011111, 0, 32'h0, 1, 0);
        nxt; #2;
        chk_out("mem_t2", 6'b011111, 0, 32'h0, 1, 0);
        nxt; stallreq_mem = 0; #2;
        chk_out("mem_t3", 6'b000000, 0, 32'h0, 1, 1);
        nxt; #2;
        chk("mem_t4.busy", {31'h0, mc_busy}, 32'h0);

        // mc_start during MC_WAIT is ignored: N=3 op still finishes at T+3.
        nxt; mc_start = 1; mc_cycles = 6'd3; #2;
        nxt; mc_cycles = 6'd20; #2;
        chk("ign_t1.ready", {31'h0, mc_ready}, 32'h0);
        nxt; mc_start = 0; #2;
        chk("ign_t2.stall", {26'h0, stall}, 32'b001111);
        nxt; #2;
        chk_out("ign_t3", 6'b000000, 0, 32'h0, 1, 1);

        // Reset mid-op.
        nxt; mc_start = 1; mc_cycles = 6'd10; #2;
        nxt; mc_start = 0; rst = 1; #2;
        chk_out("rmid_t1", 6'b000000, 0, 32'h0, 0, 0);
        nxt; rst = 0; #2;
        chk_out("rmid_t2", 6'b000000, 0, 32'h0, 0, 0);

`ifdef STALL_PERF_EN
        nxt; rst = 1; #2;
        nxt; rst = 0; stallreq_id = 1; #2;
        nxt; #2;
        nxt; #2;
        nxt; stallreq_id = 0; excp_valid = 1; excp_vector = 32'h100; #2;
        nxt; #2;
        nxt; excp_valid = 0; #2;
        chk("perf_stall", perf_stall_cycles, 32'd3);
        chk("perf_flush", perf_flush_cnt, 32'd2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
